// File: rtl/alu_seq_divider_pkg.sv
// Shared ALU definitions: default datapath width and the
// divider's state encoding.
package alu_defs;

   localparam int ALU_WIDTH = 8;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = IDLE,
      S_RUN  = RUN,
      S_DONE = DONE
   } div_state_e;

endpackage

// File: rtl/alu_seq_divider_if.sv
// Divider request/result bundle between the ALU control FSM
// (master) and the sequential divider (slave).
//   start, dividend, divisor : request from master
//   busy, done               : handshake status from slave
//   quotient, remainder      : registered results
//   div_by_zero              : last accepted divisor was zero
import alu_defs::*;

interface alu_seq_divider_if #(
   parameter int WIDTH = ALU_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start,
      output dividend,
      output divisor,
      input  busy,
      input  done,
      input  quotient,
      input  remainder,
      input  div_by_zero
   );

   modport slave (
      input  start,
      input  dividend,
      input  divisor,
      output busy,
      output done,
      output quotient,
      output remainder,
      output div_by_zero
   );

endinterface

// File: rtl/alu_seq_divider_div_step.sv
// One restoring-division iteration: trial subtract of the
// shifted partial remainder against the divisor.
//   r_i     : partial remainder low WIDTH bits
//   q_msb_i : dividend bit shifted into the remainder
//   d_i     : divisor
//   r_o     : next partial remainder (WIDTH+1 bits)
//   q_bit_o : quotient bit produced by this iteration
import alu_defs::*;

module div_step #(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] r_i,
   input  logic             q_msb_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH:0]   r_o,
   output logic             q_bit_o
);

   logic [WIDTH:0] a;
   logic [WIDTH:0] nb;
   logic [WIDTH:0] p;
   logic [WIDTH:0] g;
   logic [WIDTH:0] t;

   assign a  = {r_i, q_msb_i};
   assign nb = ~{1'b0, d_i};
   assign p  = a ^ nb;
   assign g  = a & nb;

   // a + ~b + 1 built from propagate/generate sum bits,
   // the same primitives the ALU adder uses.
   always_comb begin : sub_chain
      logic c;
      c = 1'b1;
      t = '0;
      for (int i = 0; i <= WIDTH; i++) begin
         t[i] = p[i] ^ c;
         c    = g[i] | (p[i] & c);
      end
   end

   // Partial remainder stays below the divisor, so the
   // WIDTH+1 bit difference never wraps and t[WIDTH] is
   // a true sign bit.
   assign q_bit_o = ~t[WIDTH];
   assign r_o     = t[WIDTH] ? a : t;

endmodule

// File: rtl/alu_seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit
// per clock, start/busy/done handshake on a slave bus.
//   clk   : rising-edge clock
//   rst_n : async active-low reset
//   bus   : request/result bundle (slave modport)
import alu_defs::*;

module alu_seq_divider #(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_seq_divider_if.slave bus
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   step_r;
   logic             step_qb;
   logic [WIDTH-1:0] q_shift;
   logic             r_msb_unused;

   // The extra remainder bit only carries the trial
   // difference's sign; it is always zero once stored.
   assign r_msb_unused = r_q[WIDTH];

   div_step #(
      .WIDTH   (WIDTH)
   ) u_step (
      .r_i     (r_q[WIDTH-1:0]),
      .q_msb_i (q_q[WIDTH-1]),
      .d_i     (d_q),
      .r_o     (step_r),
      .q_bit_o (step_qb)
   );

   assign q_shift = {q_q[WIDTH-2:0], step_qb};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               q_d   = bus.dividend;
               d_d   = bus.divisor;
               r_d   = '0;
               cnt_d = CNT_INIT;
               if (bus.divisor == '0) begin
                  // Skip the iterations; results are
                  // defined directly.
                  state_d = S_DONE;
                  quot_d  = '1;
                  rem_d   = bus.dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            r_d = step_r;
            q_d = q_shift;
            if (cnt_q == '0) begin
               state_d = S_DONE;
               quot_d  = q_shift;
               rem_d   = step_r[WIDTH-1:0];
               dbz_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = (state_q == S_DONE);
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/alu_seq_divider.md
Name: alu_seq_divider

Overview:
- Multi-cycle unsigned restoring divider for the ALU.
- It is the inverse-direction companion of the adder/sigma datapath: it undoes multiplication by repeated trial subtraction.
- It computes one quotient bit per clock.
- Results are presented with a start/busy/done handshake to the ALU control FSM.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits (must be >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  WIDTH  numerator; latched on accepted start.
- divisor  input  WIDTH  denominator; latched on accepted start.
- busy  output  1  high in RUN and DONE; start ignored while high.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag: last accepted division had divisor == 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset (async assert, sync release):
  - state=IDLE, busy=0, done=0.
  - quotient=0, remainder=0, div_by_zero=0.
  - All working registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge k: latch dividend into working shift reg Q and divisor into D; clear partial remainder R (WIDTH+1 bits); load iteration counter = WIDTH-1.
  - If divisor==0: go to DONE instead of RUN.
  - Otherwise: go to RUN.
- RUN, one iteration per edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}, computed WIDTH+1 bits wide.
  - If T[WIDTH]==0 (non-negative): R = T, and Q shifts left inserting 1.
  - Else: R = {R[WIDTH-1:0], Q[WIDTH-1]} (restore), and Q shifts left inserting 0.
  - When counter==0 the iteration completes: go to DONE; else decrement the counter.
- DONE entry (registered at the same edge):
  - Normal case: quotient=Q result, remainder=R[WIDTH-1:0], div_by_zero=0.
  - Divide-by-zero case: quotient = all ones, remainder = dividend, div_by_zero=1.
  - done=1 for exactly one cycle; next edge goes to IDLE with busy=0 and done=0.
- Latency:
  - Accepted start at edge k; done high in the cycle after edge k+WIDTH (normal case).
  - Done high in the cycle after edge k (divide-by-zero case).
  - Next start is accepted no earlier than edge k+WIDTH+2, since it must arrive in IDLE.
- Output stability: quotient, remainder and div_by_zero hold their values from DONE entry until the next DONE entry or reset. They do not change during RUN.
- Input stability: start, dividend and divisor are ignored outside IDLE. Changing operands mid-RUN has no effect.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. done is not asserted for the aborted operation.
- Start held high continuously: a new operation is accepted on every IDLE cycle (back-to-back, one IDLE cycle between operations).
- Arithmetic: unsigned only. R never exceeds D-1 after any iteration. No overflow is possible for divisor != 0.

Decomposition:
- Shared package alu_defs holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default ALU WIDTH constant.
- One natural sub-module: div_step, a combinational trial subtract of WIDTH+1 bits.
  - Inputs: R, Q msb, D.
  - Outputs: next R and quotient bit.
  - Its difference is built from propagate/generate bit logic, so the ALU's sum-bit primitives are reused.

Test Plan (WIDTH=8):
- Normal: start with 100/7 at edge k -> done high in the cycle after edge k+8; quotient=14, remainder=2, div_by_zero=0, busy low one cycle later.
- Extremes: 255/1 -> q=255, r=0. Then 5/9 -> q=0, r=5. Then 200/200 -> q=1, r=0.
- Divide by zero: 77/0 -> done in the cycle after the accepting edge; q=8'hFF, r=77, div_by_zero=1. A following 9/3 then gives q=3, r=0, div_by_zero=0.
- Protocol: pulse start during RUN with different operands -> ignored; results match the first operands. Hold start high -> consecutive operations separated by exactly one IDLE cycle.
- Reset: assert rst_n=0 at iteration 4 of 100/7 -> outputs and busy go to 0 immediately with no done pulse. After release, 50/6 -> q=8, r=2.
- Random: 1000 random operand pairs, divisor != 0 -> q*divisor + r == dividend and r < divisor, checked against a reference model.
